uart_tx_feeder: RTL and testbench



---
 rtl/uart_tx_feeder.sv | 187 ++++++++++++++++++
 tb/tb_uart_tx_feeder.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder
// ----------------------------------------------------------------------------
// Host-side producer for the UART transmitter's parallel interface
// (P_DATA_TX / DATA_VALID_TX / BUSY_TX). Bytes pushed by system logic are held
// in a small synchronous FIFO. A four-state launcher pops one byte at a time,
// presents it with a single-cycle DATA_VALID_TX pulse, and then uses BUSY_TX
// to pace the next launch. Everything runs in the transmitter's clock domain.
//
// Handshake (producer side): a launch is issued only from IDLE while the FIFO
// is non-empty and BUSY_TX is low. DATA_VALID_TX is high for exactly one
// cycle, with P_DATA_TX valid in that cycle and held stable until the next
// launch. The transmitter acknowledges by raising BUSY_TX. If BUSY_TX does not
// rise within BUSY_TO cycles, the byte is treated as lost and TX_ERR is set.
// When BUSY_TX falls, the launcher spends one cycle in IDLE before the next
// launch.
//
// Ports:
//   CLK, RST       clock; synchronous active-high reset
//   WR_DATA, WR_EN push interface (one byte per cycle, dropped when FULL)
//   FULL, EMPTY    registered FIFO status
//   COUNT          registered FIFO occupancy (0..DEPTH)
//   OVERFLOW       sticky: a push was dropped because FULL was set
//   TX_ERR         sticky: BUSY_TX never rose after a launch
//   BUSY_TX        transmitter busy
//   P_DATA_TX      byte presented to the transmitter
//   DATA_VALID_TX  one-cycle launch pulse
//   fsm_state      launcher state for observation
//                  (0 IDLE, 1 LAUNCH, 2 WAIT_BUSY, 3 WAIT_DONE)
// ----------------------------------------------------------------------------
module uart_tx_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = 3,
    parameter int BUSY_TO    = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic                  WR_EN,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic [ADDR_W:0]       COUNT,
    output logic                  OVERFLOW,
    output logic                  TX_ERR,
    input  logic                  BUSY_TX,
    output logic [DATA_WIDTH-1:0] P_DATA_TX,
    output logic                  DATA_VALID_TX,
    output logic [1:0]            fsm_state
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam int TO_W = $clog2(BUSY_TO + 1);

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]     wr_ptr;
    logic [ADDR_W-1:0]     rd_ptr;
    logic [ADDR_W:0]       count_nx;
    logic                  push;
    logic                  pop;

    // FULL is the registered flag. A push while FULL is set is dropped,
    // even when the launcher pops in the same cycle.
    assign push = WR_EN && !FULL;

    always_comb begin
        count_nx = COUNT;
        case ({push, pop})
            2'b10:   count_nx = COUNT + (ADDR_W+1)'(1);
            2'b01:   count_nx = COUNT - (ADDR_W+1)'(1);
            default: count_nx = COUNT;
        endcase
    end

    // Storage has no reset. After RST, stale entries cannot be read because
    // the pointers and occupancy return to zero.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= WR_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            COUNT    <= '0;
            FULL     <= 1'b0;
            EMPTY    <= 1'b1;
            OVERFLOW <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            COUNT <= count_nx;
            FULL  <= (count_nx == (ADDR_W+1)'(DEPTH));
            EMPTY <= (count_nx == '0);
            if (WR_EN && FULL) begin
                OVERFLOW <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Launcher FSM
    // ------------------------------------------------------------------
    state_t          state;
    state_t          state_nx;
    logic [TO_W-1:0] to_cnt;
    logic [TO_W-1:0] to_cnt_nx;
    logic            err_set;

    always_comb begin
        state_nx  = state;
        to_cnt_nx = to_cnt;
        pop       = 1'b0;
        err_set   = 1'b0;
        case (state)
            IDLE: begin
                // A transmitter that is busy for another reason blocks
                // the launch.
                if (!EMPTY && !BUSY_TX) begin
                    pop      = 1'b1;
                    state_nx = LAUNCH;
                end
            end
            LAUNCH: begin
                to_cnt_nx = '0;
                state_nx  = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (BUSY_TX) begin
                    state_nx = WAIT_DONE;
                end else if (to_cnt == TO_W'(BUSY_TO - 1)) begin
                    // BUSY_TX stayed low for BUSY_TO cycles. The byte is
                    // lost and is not retried.
                    err_set  = 1'b1;
                    state_nx = IDLE;
                end else begin
                    to_cnt_nx = to_cnt + TO_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!BUSY_TX) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            to_cnt        <= '0;
            TX_ERR        <= 1'b0;
            P_DATA_TX     <= '0;
            DATA_VALID_TX <= 1'b0;
        end else begin
            state         <= state_nx;
            to_cnt        <= to_cnt_nx;
            DATA_VALID_TX <= pop;
            // P_DATA_TX is loaded only on a launch, so it stays stable
            // until the next one.
            if (pop) begin
                P_DATA_TX <= mem[rd_ptr];
            end
            if (err_set) begin
                TX_ERR <= 1'b1;
            end
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder
// ----------------------------------------------------------------------------
// Drives uart_tx_feeder against a behavioural 8N1 transmitter that produces
// BUSY_TX and a serial line, and decodes that line back into bytes. A queue
// model of the FIFO predicts the byte for every launch and the
// COUNT/FULL/EMPTY/OVERFLOW values at every clock. Bytes that reach the
// serial line are pushed into exp_q and compared by the decoder.
// ----------------------------------------------------------------------------
module tb_uart_tx_feeder;
  localparam int DW      = 8;
  localparam int DEPTH   = 8;
  localparam int AW      = 3;
  localparam int BUSY_TO = 4;
  localparam int BIT     = 4;  // clocks per serial bit

  // ---------------- clock / reset / DUT ----------------
  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [DW-1:0] WR_DATA = '0;
  logic          WR_EN = 1'b0;
  logic          FULL, EMPTY, OVERFLOW, TX_ERR, BUSY_TX, DATA_VALID_TX;
  logic [AW:0]   COUNT;
  logic [DW-1:0] P_DATA_TX;
  logic [1:0]    fsm_state;

  logic force_hi  = 1'b0;  // transmitter busy from elsewhere
  logic force_lo  = 1'b0;  // BUSY_TX tied low, transmitter absent
  logic uart_busy = 1'b0;
  logic tx_out    = 1'b1;

  assign BUSY_TX = force_lo ? 1'b0 : (force_hi | uart_busy);

  always #5 CLK = ~CLK;

  uart_tx_feeder #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_W(AW), .BUSY_TO(BUSY_TO)) dut (
    .CLK(CLK), .RST(RST), .WR_DATA(WR_DATA), .WR_EN(WR_EN),
    .FULL(FULL), .EMPTY(EMPTY), .COUNT(COUNT), .OVERFLOW(OVERFLOW),
    .TX_ERR(TX_ERR), .BUSY_TX(BUSY_TX), .P_DATA_TX(P_DATA_TX),
    .DATA_VALID_TX(DATA_VALID_TX), .fsm_state(fsm_state)
  );

  // ---------------- scoreboard state ----------------
  int            n_checks = 0;
  int            n_fail   = 0;
  int            launches = 0;
  logic [DW-1:0] mdl_q[$];  // reference FIFO contents
  logic [DW-1:0] exp_q[$];  // bytes expected on the serial line
  logic          mdl_ovf = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the following negedge.
  task automatic push_byte(input logic [DW-1:0] d);
    WR_EN = 1'b1;
    WR_DATA = d;
    @(negedge CLK);
    WR_EN = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int i;
    i = 0;
    while (i < budget && !(mdl_q.size() == 0 && exp_q.size() == 0 && !uart_busy &&
                           fsm_state == 2'd0 && !DATA_VALID_TX)) begin
      @(negedge CLK);
      i++;
    end
    if (i >= budget) flag_fail({name, "_drain_timeout"});
  endtask

  task automatic wait_launch(input string name, input int budget, output bit seen);
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge CLK);
      #1;
      if (DATA_VALID_TX === 1'b1) seen = 1;
    end
    if (!seen) flag_fail({name, "_launch_timeout"});
  endtask

  // ---------------- behavioural 8N1 transmitter ----------------
  initial begin
    logic [9:0] frame;
    forever begin
      @(negedge CLK);
      if (DATA_VALID_TX === 1'b1 && !force_lo && !uart_busy) begin
        frame = {1'b1, P_DATA_TX, 1'b0};
        uart_busy = 1'b1;
        for (int b = 0; b < 10; b++) begin
          tx_out = frame[b];
          repeat (BIT) @(negedge CLK);
        end
        uart_busy = 1'b0;
      end
    end
  end

  // ---------------- serial decoder ----------------
  initial begin
    logic [DW-1:0] r;
    logic [DW-1:0] e;
    forever begin
      @(posedge CLK);
      if (tx_out === 1'b0) begin
        repeat (BIT/2) @(posedge CLK);
        for (int i = 0; i < DW; i++) begin
          repeat (BIT) @(posedge CLK);
          r[i] = tx_out;
        end
        repeat (BIT) @(posedge CLK);
        check("stop_bit", 32'(tx_out), 32'd1);
        if (exp_q.size() == 0) flag_fail("unexpected_serial_frame");
        else begin
          e = exp_q.pop_front();
          check("serial_byte", 32'(r), 32'(e));
        end
      end
    end
  end

  // ---------------- monitor / reference model ----------------
  initial begin
    logic          s_rst, s_we, s_busy, prev_dv;
    logic [DW-1:0] s_wd, e;
    int            pre;
    prev_dv = 1'b0;
    forever begin
      @(posedge CLK);
      s_rst  = RST;
      s_we   = WR_EN;
      s_wd   = WR_DATA;
      s_busy = BUSY_TX;
      pre    = mdl_q.size();
      #1;
      if (s_rst) begin
        mdl_q.delete();
        mdl_ovf = 1'b0;
        check("rst_dv", 32'(DATA_VALID_TX), 32'd0);
      end else begin
        if (DATA_VALID_TX === 1'b1) begin
          check("launch_pulse_width", 32'(prev_dv), 32'd0);
          check("launch_while_busy", 32'(s_busy), 32'd0);
          if (mdl_q.size() == 0) flag_fail("launch_from_empty");
          else begin
            e = mdl_q.pop_front();
            check("launch_data", 32'(P_DATA_TX), 32'(e));
            if (!force_lo) exp_q.push_back(e);
            launches++;
          end
        end
        if (s_we) begin
          if (pre == DEPTH) mdl_ovf = 1'b1;
          else mdl_q.push_back(s_wd);
        end
      end
      check("count", 32'(COUNT), 32'(mdl_q.size()));
      check("empty", 32'(EMPTY), 32'(mdl_q.size() == 0));
      check("full", 32'(FULL), 32'(mdl_q.size() == DEPTH));
      check("overflow", 32'(OVERFLOW), 32'(mdl_ovf));
      prev_dv = DATA_VALID_TX;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit            seen;
    int            base;
    logic [DW-1:0] d;

    // Reset
    repeat (2) @(negedge CLK);
    check("rst_count", 32'(COUNT), 32'd0);
    check("rst_empty", 32'(EMPTY), 32'd1);
    check("rst_full", 32'(FULL), 32'd0);
    check("rst_overflow", 32'(OVERFLOW), 32'd0);
    check("rst_tx_err", 32'(TX_ERR), 32'd0);
    check("rst_p_data", 32'(P_DATA_TX), 32'd0);
    check("rst_valid", 32'(DATA_VALID_TX), 32'd0);
    check("rst_state", 32'(fsm_state), 32'd0);
    RST = 1'b0;
    @(negedge CLK);

    // Single byte: exact launch latency
    WR_DATA = 8'hA5;
    WR_EN = 1'b1;
    @(posedge CLK);
    #1;
    check("t1_not_empty", 32'(EMPTY), 32'd0);
    check("t1_no_early_launch", 32'(DATA_VALID_TX), 32'd0);
    @(negedge CLK);
    WR_EN = 1'b0;
    @(posedge CLK);
    #1;
    check("t1_launch", 32'(DATA_VALID_TX), 32'd1);
    check("t1_data", 32'(P_DATA_TX), 32'hA5);
    @(negedge CLK);
    wait_drain("t1", 300);
    check("t1_launches", 32'(launches), 32'd1);
    check("t1_empty_end", 32'(EMPTY), 32'd1);

    // Burst of 0x01..0x08 held off until FULL, then released
    force_hi = 1'b1;
    for (int i = 1; i <= 8; i++) push_byte(8'(i));
    check("t2_full", 32'(FULL), 32'd1);
    check("t2_count", 32'(COUNT), 32'd8);
    check("t2_no_overflow", 32'(OVERFLOW), 32'd0);
    force_hi = 1'b0;
    wait_drain("t2", 1500);
    check("t2_launches", 32'(launches), 32'd9);

    // Nine pushes while busy: the ninth is dropped
    force_hi = 1'b1;
    for (int i = 0; i < 9; i++) push_byte(8'($urandom));
    check("t3_overflow", 32'(OVERFLOW), 32'd1);
    check("t3_count", 32'(COUNT), 32'd8);
    repeat (5) @(negedge CLK);
    check("t3_overflow_sticky", 32'(OVERFLOW), 32'd1);
    check("t3_no_launch_while_busy", 32'(launches), 32'd9);
    force_hi = 1'b0;
    wait_drain("t3", 1500);
    check("t3_launches", 32'(launches), 32'd17);
    check("t3_overflow_end", 32'(OVERFLOW), 32'd1);

    // BUSY_TX tied low: timeout after four waiting cycles
    force_lo = 1'b1;
    push_byte(8'h3C);
    wait_launch("t4a", 10, seen);
    check("t4_data", 32'(P_DATA_TX), 32'h3C);
    for (int k = 1; k <= 5; k++) begin
      @(posedge CLK);
      #1;
      if (k == 4) check("t4_err_not_yet", 32'(TX_ERR), 32'd0);
      if (k == 5) begin
        check("t4_err_set", 32'(TX_ERR), 32'd1);
        check("t4_state_idle", 32'(fsm_state), 32'd0);
      end
    end
    @(negedge CLK);
    push_byte(8'h3D);
    wait_launch("t4b", 10, seen);
    check("t4_second_data", 32'(P_DATA_TX), 32'h3D);
    repeat (8) @(negedge CLK);
    force_lo = 1'b0;
    check("t4_err_sticky", 32'(TX_ERR), 32'd1);
    check("t4_launches", 32'(launches), 32'd19);

    // Reset during WAIT_DONE with three bytes queued
    for (int i = 0; i < 4; i++) push_byte(8'($urandom));
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (fsm_state == 2'd3) seen = 1;
      else @(negedge CLK);
    end
    if (!seen) flag_fail("t5_wait_done_timeout");
    check("t5_queued", 32'(COUNT), 32'd3);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check("t5_count", 32'(COUNT), 32'd0);
    check("t5_empty", 32'(EMPTY), 32'd1);
    check("t5_valid", 32'(DATA_VALID_TX), 32'd0);
    check("t5_overflow", 32'(OVERFLOW), 32'd0);
    check("t5_tx_err", 32'(TX_ERR), 32'd0);
    check("t5_state", 32'(fsm_state), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (60) @(negedge CLK);
    check("t5_no_more_launches", 32'(launches), 32'd20);
    wait_drain("t5", 300);

    // Simultaneous push and pop at COUNT=4
    force_hi = 1'b1;
    for (int i = 0; i < 4; i++) push_byte(8'($urandom));
    check("t6_count_before", 32'(COUNT), 32'd4);
    force_hi = 1'b0;
    WR_DATA = 8'($urandom);
    WR_EN = 1'b1;
    @(posedge CLK);
    #1;
    check("t6_count_same", 32'(COUNT), 32'd4);
    check("t6_launch", 32'(DATA_VALID_TX), 32'd1);
    @(negedge CLK);
    WR_EN = 1'b0;
    wait_drain("t6", 1000);
    check("t6_launches", 32'(launches), 32'd25);

    // Random traffic: pointer wrap, occasional overflow
    base = launches;
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 11) == 0) begin
        d = 8'($urandom);
        push_byte(d);
      end else begin
        @(negedge CLK);
      end
    end
    wait_drain("t7", 4000);
    check("t7_some_launches", 32'(launches > base), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global guard
  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

endmodule
